epb_master: RTL

- Initiator (master) end of the EPB external peripheral bus, used to drive EPB-attached slave logic in loopback and bench rigs, and to bridge an internal request port onto the EPB pins.
- Accepts one read or write request at a time through a valid/ready port.
- Sequences each EPB cycle (address setup, chip-select strobe, wait for slave ready, hold) and returns a single-cycle response with read data or a timeout flag.
- Pin-side outputs are registered; tri-state and pad buffering stay in the pad infrastructure layer.

---
 rtl/epb_master.sv | 118 +++++++++++
 1 files changed

// File: rtl/epb_master.sv
// EPB bus initiator: turns one valid/ready request into a registered EPB cycle
// (setup, chip-select strobe until slave ready or timeout, hold) and returns a one-cycle response.
module epb_master #(
   parameter int unsigned SETUP_CYCLES = 1,
   parameter int unsigned HOLD_CYCLES  = 1,
   parameter int unsigned TIMEOUT_W    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [22:0] req_addr,
   input  logic [5:0]  req_addr_gp,
   input  logic [1:0]  req_be_n,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_timeout,
   output logic        epb_cs_n,
   output logic        epb_r_w_n,
   output logic [1:0]  epb_be_n,
   output logic [22:0] epb_addr,
   output logic [5:0]  epb_addr_gp,
   output logic [15:0] epb_data_out,
   output logic        epb_data_oe_n,
   input  logic [15:0] epb_data_in,
   input  logic        epb_rdy
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYCLES - 1);

   state_t               state;
   logic [3:0]           phase_cnt;
   logic [TIMEOUT_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         phase_cnt     <= '0;
         tmo_cnt       <= '0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_timeout   <= 1'b0;
         epb_cs_n      <= 1'b1;
         epb_r_w_n     <= 1'b1;
         epb_be_n      <= '1;
         epb_addr      <= '0;
         epb_addr_gp   <= '0;
         epb_data_out  <= '0;
         epb_data_oe_n <= 1'b1;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state       <= SETUP;
                  req_ready   <= 1'b0;
                  phase_cnt   <= SETUP_LAST;
                  epb_addr    <= req_addr;
                  epb_addr_gp <= req_addr_gp;
                  epb_be_n    <= req_be_n;
                  epb_r_w_n   <= ~req_we;
                  if (req_we) begin
                     epb_data_out  <= req_wdata;
                     epb_data_oe_n <= 1'b0;
                  end
               end
            end
            SETUP: begin
               if (phase_cnt == 4'd0) begin
                  state    <= STROBE;
                  epb_cs_n <= 1'b0;
                  tmo_cnt  <= '0;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            STROBE: begin
               // rdy takes priority over the terminal count
               if (epb_rdy) begin
                  if (epb_r_w_n) rsp_rdata <= epb_data_in;
                  rsp_timeout <= 1'b0;
                  state       <= HOLD;
                  epb_cs_n    <= 1'b1;
                  phase_cnt   <= HOLD_LAST;
               end else if (tmo_cnt == '1) begin
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= 16'hFFFF;
                  state       <= HOLD;
                  epb_cs_n    <= 1'b1;
                  phase_cnt   <= HOLD_LAST;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (phase_cnt == 4'd0) begin
                  state         <= IDLE;
                  req_ready     <= 1'b1;
                  rsp_valid     <= 1'b1;
                  epb_data_oe_n <= 1'b1;
                  epb_r_w_n     <= 1'b1;
                  epb_be_n      <= '1;
               end else begin
                  phase_cnt <= phase_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
